pong_game_seq: RTL and testbench



---
 rtl/pong_pkg.sv | 20 ++
 rtl/pong_game_seq_if.sv | 26 ++
 rtl/frame_tick_gen.sv | 48 ++++
 rtl/pong_game_seq.sv | 101 ++++++++++
 tb/tb_pong_game_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encodings, screen geometry and BCD helper for the pong game
package pong_pkg;
  typedef enum logic [2:0] {
    ATTRACT = 3'd0,
    SERVE   = 3'd1,
    PLAY    = 3'd2,
    POINT   = 3'd3,
    OVER    = 3'd4
  } state_t;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int H_TOTAL       = 800;
  localparam int V_TOTAL       = 525;
  localparam logic [7:0] BCD_MAX = 8'h99;
  // two-digit BCD increment that saturates at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v == BCD_MAX) ? v :
           (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/pong_game_seq_if.sv
// pong_game_seq_if: scan position, buttons, ball events and game strobes of the sequencer
interface pong_game_seq_if;
  logic [9:0] x_i;
  logic [9:0] y_i;
  logic       btn_start_i;
  logic       btn_up_i;
  logic       btn_dwn_i;
  logic       hit_i;
  logic       miss_i;
  logic       tick_o;
  logic       serve_o;
  logic       ball_step_o;
  logic       paddle_up_o;
  logic       paddle_dn_o;
  logic [7:0] score_o;
  logic [1:0] lives_o;
  logic [2:0] state_o;
  modport master (
    output x_i, y_i, btn_start_i, btn_up_i, btn_dwn_i, hit_i, miss_i,
    input  tick_o, serve_o, ball_step_o, paddle_up_o, paddle_dn_o, score_o, lives_o, state_o
  );
  modport slave (
    input  x_i, y_i, btn_start_i, btn_up_i, btn_dwn_i, hit_i, miss_i,
    output tick_o, serve_o, ball_step_o, paddle_up_o, paddle_dn_o, score_o, lives_o, state_o
  );
endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: once-per-frame tick from scan position plus frame-sampled, synchronized buttons
module frame_tick_gen #(
  parameter logic [9:0] H_TICK = 10'd0,
  parameter logic [9:0] V_TICK = 10'd480
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic       btn_start_i,
  input  logic       btn_up_i,
  input  logic       btn_dwn_i,
  output logic       tick_o,
  output logic       start_press_o,
  output logic       up_o,
  output logic       dn_o
);
  logic       match;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic       start_q;
  logic       start_prev;
  assign match = (x_i == H_TICK) && (y_i == V_TICK);
  // sampled levels only change at the scan match, so they are stable when the tick appears
  assign start_press_o = tick_o && start_q && !start_prev;
  // two-flop synchronizers, registered tick, and once-per-frame button sampling for debounce
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1      <= 3'b000;
      sync2      <= 3'b000;
      tick_o     <= 1'b0;
      start_q    <= 1'b0;
      start_prev <= 1'b0;
      up_o       <= 1'b0;
      dn_o       <= 1'b0;
    end else begin
      sync1  <= {btn_start_i, btn_up_i, btn_dwn_i};
      sync2  <= sync1;
      tick_o <= match;
      if (match) begin
        start_q    <= sync2[2];
        start_prev <= start_q;
        up_o       <= sync2[1];
        dn_o       <= sync2[0];
      end
    end
  end
endmodule

// File: rtl/pong_game_seq.sv
// pong_game_seq: game-flow FSM pacing ball and paddle steps, keeping BCD score and lives
module pong_game_seq
  import pong_pkg::*;
#(
  parameter logic [9:0] H_TICK       = 10'd0,
  parameter logic [9:0] V_TICK       = 10'd480,
  parameter logic [3:0] BALL_DIV     = 4'd1,
  parameter logic [7:0] SERVE_FRAMES = 8'd60,
  parameter logic [7:0] POINT_FRAMES = 8'd30,
  parameter logic [1:0] LIVES        = 2'd3
) (
  input logic            clk_i,
  input logic            reset_i,
  pong_game_seq_if.slave bus
);
  state_t     state;
  state_t     next_state;
  logic       entry;
  logic [7:0] frame_cnt;
  logic [3:0] ball_div;
  logic [7:0] score;
  logic [7:0] score_n;
  logic [1:0] lives;
  logic [1:0] lives_n;
  logic       tick;
  logic       start_press;
  logic       up_s;
  logic       dn_s;
  logic       paddle_ok;
  frame_tick_gen #(.H_TICK(H_TICK), .V_TICK(V_TICK)) u_tick (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .x_i           (bus.x_i),
    .y_i           (bus.y_i),
    .btn_start_i   (bus.btn_start_i),
    .btn_up_i      (bus.btn_up_i),
    .btn_dwn_i     (bus.btn_dwn_i),
    .tick_o        (tick),
    .start_press_o (start_press),
    .up_o          (up_s),
    .dn_o          (dn_s)
  );
  // strobes are decoded from registered state, tick and sampled buttons, so they line up with tick_o
  assign paddle_ok       = tick && (state == SERVE || state == PLAY);
  assign bus.tick_o      = tick;
  assign bus.serve_o     = entry && (state == SERVE);
  assign bus.ball_step_o = tick && (state == PLAY) && (ball_div == BALL_DIV - 4'd1);
  assign bus.paddle_up_o = paddle_ok && up_s && !dn_s;
  assign bus.paddle_dn_o = paddle_ok && dn_s && !up_s;
  assign bus.score_o     = score;
  assign bus.lives_o     = lives;
  assign bus.state_o     = state;
  // state, score, lives and the per-state frame and ball-step counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= ATTRACT;
      entry     <= 1'b0;
      frame_cnt <= 8'd0;
      ball_div  <= 4'd0;
      score     <= 8'h00;
      lives     <= LIVES;
    end else begin
      state     <= next_state;
      entry     <= next_state != state;
      frame_cnt <= (next_state != state) ? 8'd0 : frame_cnt + {7'd0, tick};
      ball_div  <= (state != PLAY) ? 4'd0 :
                   !tick ? ball_div :
                   (ball_div == BALL_DIV - 4'd1) ? 4'd0 : ball_div + 4'd1;
      score     <= score_n;
      lives     <= lives_n;
    end
  end
  // next state plus score/lives updates; a miss in the same cycle as a hit drops the hit
  always_comb begin
    next_state = state;
    score_n    = score;
    lives_n    = lives;
    case (state)
      ATTRACT, OVER: begin
        if (start_press) begin
          next_state = SERVE;
          score_n    = 8'h00;
          lives_n    = LIVES;
        end
      end
      SERVE: next_state = (tick && frame_cnt == SERVE_FRAMES - 8'd1) ? PLAY : SERVE;
      PLAY: begin
        if (bus.miss_i) begin
          next_state = POINT;
          lives_n    = lives - 2'd1;
        end else if (bus.hit_i) begin
          score_n = bcd_inc(score);
        end
      end
      POINT: begin
        if (tick && frame_cnt == POINT_FRAMES - 8'd1) next_state = (lives == 2'd0) ? OVER : SERVE;
      end
      default: next_state = ATTRACT;
    endcase
  end
endmodule

// File: tb/tb_pong_game_seq.sv
// tb_pong_game_seq: scoreboard bench for the pong game sequencer using compressed frames
module tb_pong_game_seq;
  import pong_pkg::*;
  localparam logic [9:0] HT = 10'd0;
  localparam logic [9:0] VT = 10'd480;
  localparam int IDLE = 7;
  typedef struct packed {
    logic   ball;
    logic   up;
    logic   dn;
    state_t st;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int last_tick = -1;
  int tick_cnt = 0;
  int ball_cnt = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int serve_cnt = 0;
  int stray = 0;
  bit gap_en = 1'b0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  pong_game_seq_if bus();
  pong_game_seq #(
    .H_TICK(HT), .V_TICK(VT), .BALL_DIV(4'd2), .SERVE_FRAMES(8'd4), .POINT_FRAMES(8'd2), .LIVES(2'd3)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_btn(input bit s, input bit u, input bit d);
    bus.btn_start_i = s;
    bus.btn_up_i    = u;
    bus.btn_dwn_i   = d;
    cyc(3);
  endtask
  task automatic frame(input bit b, input bit u, input bit d, input state_t s);
    exp_q.push_back('{ball: b, up: u, dn: d, st: s});
    bus.x_i = HT;
    bus.y_i = VT;
    cyc();
    for (int i = 0; i < IDLE; i++) begin
      bus.x_i = (i % 2 == 1) ? HT : HT + 10'd1;
      bus.y_i = (i % 2 == 1) ? VT + 10'd1 : VT;
      cyc();
    end
  endtask
  task automatic pulse(input bit h, input bit m);
    bus.hit_i  = h;
    bus.miss_i = m;
    cyc();
    bus.hit_i  = 1'b0;
    bus.miss_i = 1'b0;
  endtask
  task automatic check_state(input string tag, input state_t s, input logic [7:0] sc, input logic [1:0] lv);
    check({tag, "_state"}, bus.state_o, s);
    check({tag, "_score"}, bus.score_o, sc);
    check({tag, "_lives"}, bus.lives_o, lv);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc_n++;
    if (bus.serve_o) serve_cnt++;
    if (!bus.tick_o && (bus.ball_step_o || bus.paddle_up_o || bus.paddle_dn_o)) stray++;
    if (bus.tick_o) begin
      tick_cnt++;
      if (gap_en && last_tick >= 0) check("tick_gap", cyc_n - last_tick, IDLE + 1);
      last_tick = cyc_n;
      ball_cnt += int'(bus.ball_step_o);
      up_cnt   += int'(bus.paddle_up_o);
      dn_cnt   += int'(bus.paddle_dn_o);
      if (exp_q.size() == 0) begin
        check("tick_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ball_step", bus.ball_step_o, e.ball);
        check("paddle_up", bus.paddle_up_o, e.up);
        check("paddle_dn", bus.paddle_dn_o, e.dn);
        check("tick_state", bus.state_o, e.st);
      end
    end
  end
  initial begin
    bus.x_i = HT + 10'd5;
    bus.y_i = 10'd5;
    bus.btn_start_i = 1'b0;
    bus.btn_up_i = 1'b0;
    bus.btn_dwn_i = 1'b0;
    bus.hit_i = 1'b0;
    bus.miss_i = 1'b0;
    cyc(3);
    check_state("reset", ATTRACT, 8'h00, 2'd3);
    check("reset_tick", bus.tick_o, 0);
    check("reset_serve", bus.serve_o, 0);
    check("reset_strobes", {bus.ball_step_o, bus.paddle_up_o, bus.paddle_dn_o}, 0);
    rst = 1'b0;
    set_btn(0, 1, 0);
    gap_en = 1'b1;
    repeat (3) frame(0, 0, 0, ATTRACT);
    gap_en = 1'b0;
    check("attract_ticks", tick_cnt, 3);
    check_state("attract", ATTRACT, 8'h00, 2'd3);
    set_btn(1, 0, 0);
    frame(0, 0, 0, ATTRACT);
    check_state("start", SERVE, 8'h00, 2'd3);
    check("serve_pulse1", serve_cnt, 1);
    frame(0, 0, 0, SERVE);
    set_btn(0, 1, 0);
    frame(0, 1, 0, SERVE);
    set_btn(0, 0, 0);
    frame(0, 0, 0, SERVE);
    check("serve_hold", bus.state_o, SERVE);
    frame(0, 0, 0, SERVE);
    check_state("play_entry", PLAY, 8'h00, 2'd3);
    check("serve_once", serve_cnt, 1);
    ball_cnt = 0;
    up_cnt = 0;
    dn_cnt = 0;
    set_btn(0, 1, 0);
    for (int i = 0; i < 10; i++) frame(i % 2 == 1, 1, 0, PLAY);
    check("ball_steps", ball_cnt, 5);
    check("up_steps", up_cnt, 10);
    set_btn(0, 1, 1);
    for (int i = 10; i < 12; i++) frame(i % 2 == 1, 0, 0, PLAY);
    set_btn(0, 0, 1);
    for (int i = 12; i < 14; i++) frame(i % 2 == 1, 0, 1, PLAY);
    set_btn(0, 0, 0);
    check("dn_steps", dn_cnt, 2);
    for (int n = 1; n <= 100; n++) begin
      pulse(1, 0);
      check("score", bus.score_o, to_bcd(n > 99 ? 99 : n));
    end
    check_state("hits", PLAY, 8'h99, 2'd3);
    pulse(1, 1);
    check_state("hit_miss", POINT, 8'h99, 2'd2);
    set_btn(0, 1, 0);
    repeat (2) frame(0, 0, 0, POINT);
    check_state("point1", SERVE, 8'h99, 2'd2);
    check("serve_pulse2", serve_cnt, 2);
    set_btn(0, 0, 0);
    repeat (4) frame(0, 0, 0, SERVE);
    check("play2", bus.state_o, PLAY);
    pulse(0, 1);
    check_state("miss2", POINT, 8'h99, 2'd1);
    repeat (2) frame(0, 0, 0, POINT);
    check_state("point2", SERVE, 8'h99, 2'd1);
    check("serve_pulse3", serve_cnt, 3);
    repeat (4) frame(0, 0, 0, SERVE);
    check("play3", bus.state_o, PLAY);
    pulse(0, 1);
    check_state("miss3", POINT, 8'h99, 2'd0);
    repeat (2) frame(0, 0, 0, POINT);
    check_state("over", OVER, 8'h99, 2'd0);
    set_btn(0, 1, 0);
    frame(0, 0, 0, OVER);
    check_state("over_hold", OVER, 8'h99, 2'd0);
    set_btn(1, 0, 0);
    frame(0, 0, 0, OVER);
    check_state("restart", SERVE, 8'h00, 2'd3);
    check("serve_pulse4", serve_cnt, 4);
    set_btn(0, 0, 0);
    pulse(1, 1);
    check_state("ignored", SERVE, 8'h00, 2'd3);
    repeat (4) frame(0, 0, 0, SERVE);
    pulse(1, 0);
    pulse(1, 0);
    check_state("play4", PLAY, 8'h02, 2'd3);
    set_btn(0, 1, 0);
    bus.x_i = HT;
    bus.y_i = VT;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.x_i = HT + 10'd5;
    bus.y_i = 10'd5;
    check_state("mid_reset", ATTRACT, 8'h00, 2'd3);
    check("mid_reset_tick", bus.tick_o, 0);
    check("mid_reset_strobes", {bus.serve_o, bus.ball_step_o, bus.paddle_up_o, bus.paddle_dn_o}, 0);
    cyc(3);
    check("stray_strobes", stray, 0);
    check("queue_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
